// File: rtl/tt_adder_operand_seq_pkg.sv
// ---------------------------------------------------------------------------
// tt_adder_pkg
// Shared definitions for the nibble-adder operand sequencer:
//   - seq_state_e : sequencer states (IDLE, MAN_SETTLE, SWP_SETTLE, DONE)
//   - operand bus field layout (A nibble at [3:0], B nibble at [7:4])
//   - settle counter width and last sweep operand value
//   - sig_next()  : one rotate-left-by-one then XOR signature step
// ---------------------------------------------------------------------------
package tt_adder_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        MAN_SETTLE = 2'd1,
        SWP_SETTLE = 2'd2,
        DONE       = 2'd3
    } seq_state_e;

    // Operand bus layout: {B, A}
    localparam int A_LSB = 0;
    localparam int B_LSB = 4;
    localparam int NIB_W = 4;

    // Settle counter width; bounds SETTLE_CYC to 1..15
    localparam int CNT_W = 4;

    // Final operand pair of an exhaustive sweep
    localparam logic [7:0] OP_LAST = 8'hFF;

    // Signature step: rotate the running signature left by one, fold in result
    function automatic logic [7:0] sig_next(input logic [7:0] sig, input logic [7:0] res);
        sig_next = {sig[6:0], sig[7]} ^ res;
    endfunction

endpackage

// File: rtl/tt_adder_operand_seq_if.sv
// ---------------------------------------------------------------------------
// tt_adder_operand_seq_if
// Bundles the control, operand and result signals of the operand sequencer.
//   slave  : the sequencer (accepts start/loads, drives operand bus, samples
//            the adder result, reports res_q/res_valid/busy/sig_q)
//   master : the controlling environment plus the adder result feed
// Signals:
//   start, load_valid, load_sel, load_data : control from master
//   op_out  [7:0] : operand bus {B, A} to the adder
//   res_in  [7:0] : adder result back to the sequencer
//   res_q   [7:0] : last captured result
//   res_valid     : pulse one cycle after res_q updates
//   busy          : settle or sweep in progress
//   sig_q   [7:0] : running sweep signature
// ---------------------------------------------------------------------------
interface tt_adder_operand_seq_if;

    logic       start;
    logic       load_valid;
    logic       load_sel;
    logic [3:0] load_data;
    logic [7:0] op_out;
    logic [7:0] res_in;
    logic [7:0] res_q;
    logic       res_valid;
    logic       busy;
    logic [7:0] sig_q;

    modport slave (
        input  start,
        input  load_valid,
        input  load_sel,
        input  load_data,
        input  res_in,
        output op_out,
        output res_q,
        output res_valid,
        output busy,
        output sig_q
    );

    modport master (
        output start,
        output load_valid,
        output load_sel,
        output load_data,
        output res_in,
        input  op_out,
        input  res_q,
        input  res_valid,
        input  busy,
        input  sig_q
    );

endinterface

// File: rtl/tt_adder_operand_seq_settle.sv
// ---------------------------------------------------------------------------
// tt_settle_timer
// Settle-window counter for the operand sequencer. clr restarts the window at
// count 0; en advances it by one per cycle. done is registered and is high
// during the cycle whose count equals SETTLE_CYC-1, i.e. the last cycle of a
// window of SETTLE_CYC cycles.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : restart the window (priority over en)
//   en         : advance the count
//   done       : last cycle of the current window
// Parameter SETTLE_CYC must lie in 1..15.
// ---------------------------------------------------------------------------
module tt_settle_timer
    import tt_adder_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYC - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             done_r;

    assign cnt_inc_s = cnt_r + CNT_W'(1);

    // Window counter; done is precomputed from the value being loaded so the
    // strobe comes straight from a flop. With SETTLE_CYC==1 every window is
    // a single cycle, so a restart immediately flags done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            done_r <= 1'b0;
        end else if (clr) begin
            cnt_r  <= '0;
            done_r <= (LAST_CNT == '0);
        end else if (en) begin
            cnt_r  <= cnt_inc_s;
            done_r <= (cnt_inc_s == LAST_CNT);
        end else begin
            cnt_r  <= cnt_r;
            done_r <= done_r;
        end
    end

    assign done = done_r;

endmodule

// File: rtl/tt_adder_operand_seq.sv
// ---------------------------------------------------------------------------
// tt_adder_operand_seq
// Operand stage for the 8-pin nibble adder tile. Drives the operand bus
// {B[3:0], A[3:0]} from either manual nibble loads or an exhaustive sweep of
// all 256 operand pairs, holds each operand for SETTLE_CYC cycles, samples
// the combinational adder result on the last cycle of the window, and folds
// sweep results into a rotate-XOR signature.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset (aborts any sweep)
//   bus    : tt_adder_operand_seq_if.slave (start, load_*, op_out, res_in,
//            res_q, res_valid, busy, sig_q)
// Parameters:
//   SETTLE_CYC : cycles op_out is stable before sampling, 1..15
//   SIG_SEED   : signature value loaded on reset and at sweep start
// ---------------------------------------------------------------------------
module tt_adder_operand_seq
    import tt_adder_pkg::*;
#(
    parameter int         SETTLE_CYC = 2,
    parameter logic [7:0] SIG_SEED   = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tt_adder_operand_seq_if.slave bus
);

    seq_state_e state_r;
    logic [7:0] op_r;
    logic [7:0] res_q_r;
    logic [7:0] sig_r;
    logic       cap_r;
    logic       res_valid_r;
    logic       busy_r;

    logic       timer_clr_s;
    logic       timer_en_s;
    logic       timer_done_s;
    logic       capture_s;

    tt_settle_timer #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr_s),
        .en    (timer_en_s),
        .done  (timer_done_s)
    );

    // Settle timer control and result-capture strobe, decoded from state.
    // The window restarts whenever a new operand is presented: on acceptance
    // in IDLE and after each non-final sweep capture.
    always_comb begin
        timer_clr_s = 1'b0;
        timer_en_s  = 1'b0;
        capture_s   = 1'b0;
        case (state_r)
            IDLE: begin
                timer_clr_s = bus.start | bus.load_valid;
            end
            MAN_SETTLE: begin
                capture_s  = timer_done_s;
                timer_en_s = ~timer_done_s;
            end
            SWP_SETTLE: begin
                capture_s   = timer_done_s;
                timer_en_s  = ~timer_done_s;
                timer_clr_s = timer_done_s & (op_r != OP_LAST);
            end
            DONE: begin
                timer_clr_s = 1'b0;
            end
            default: begin
                timer_clr_s = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with operand, result, signature and status registers.
    // res_valid trails the capture by one cycle (cap_r stages it) so it is
    // seen in the cycle after res_q has updated. op_out only moves at the
    // capture edge that ends a window, so the adder input is stable for the
    // whole window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            op_r        <= 8'h00;
            res_q_r     <= 8'h00;
            sig_r       <= SIG_SEED;
            cap_r       <= 1'b0;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            cap_r       <= capture_s;
            res_valid_r <= cap_r;
            case (state_r)
                IDLE: begin
                    // start wins over a same-cycle load; that load is dropped
                    if (bus.start) begin
                        op_r    <= 8'h00;
                        sig_r   <= SIG_SEED;
                        busy_r  <= 1'b1;
                        state_r <= SWP_SETTLE;
                    end else if (bus.load_valid) begin
                        if (bus.load_sel) begin
                            op_r[B_LSB +: NIB_W] <= bus.load_data;
                        end else begin
                            op_r[A_LSB +: NIB_W] <= bus.load_data;
                        end
                        busy_r  <= 1'b1;
                        state_r <= MAN_SETTLE;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                MAN_SETTLE: begin
                    if (capture_s) begin
                        res_q_r <= bus.res_in;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        busy_r  <= 1'b1;
                        state_r <= MAN_SETTLE;
                    end
                end
                SWP_SETTLE: begin
                    if (capture_s) begin
                        res_q_r <= bus.res_in;
                        sig_r   <= sig_next(sig_r, bus.res_in);
                        // Wrap is detected before incrementing so op_out
                        // rests at 8'hFF once the sweep is complete.
                        if (op_r == OP_LAST) begin
                            busy_r  <= 1'b0;
                            state_r <= DONE;
                        end else begin
                            op_r    <= op_r + 8'h01;
                            busy_r  <= 1'b1;
                            state_r <= SWP_SETTLE;
                        end
                    end else begin
                        busy_r  <= 1'b1;
                        state_r <= SWP_SETTLE;
                    end
                end
                DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.op_out    = op_r;
    assign bus.res_q     = res_q_r;
    assign bus.res_valid = res_valid_r;
    assign bus.busy      = busy_r;
    assign bus.sig_q     = sig_r;

endmodule

// File: tb/tb_tt_adder_operand_seq.sv
// ---------------------------------------------------------------------------
// tb_tt_adder_operand_seq
// Self-checking bench for tt_adder_operand_seq. Two instances:
//   dut  : SETTLE_CYC=2, SIG_SEED=8'h00, adder model selectable between
//          A+B and a pass-through of op_out
//   dut3 : SETTLE_CYC=3, SIG_SEED=8'hA5, result is op_out delayed 2 cycles
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_tt_adder_operand_seq;

    localparam int         S2    = 2;
    localparam int         S3    = 3;
    localparam logic [7:0] SEED2 = 8'h00;
    localparam logic [7:0] SEED3 = 8'hA5;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       add_mode = 1'b1;
    logic [7:0] d1_r     = 8'h00;
    logic [7:0] d2_r     = 8'h00;
    logic [3:0] a_m      = 4'h0;
    logic [3:0] b_m      = 4'h0;
    int         n_checks = 0;
    int         n_fail   = 0;

    tt_adder_operand_seq_if bus ();
    tt_adder_operand_seq_if bus3 ();

    tt_adder_operand_seq #(.SETTLE_CYC(S2), .SIG_SEED(SEED2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    tt_adder_operand_seq #(.SETTLE_CYC(S3), .SIG_SEED(SEED3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    always #5 clk = ~clk;

    // Adder models
    assign bus.res_in = add_mode ? ({4'h0, bus.op_out[3:0]} + {4'h0, bus.op_out[7:4]})
                                 : bus.op_out;

    always @(posedge clk) begin
        d1_r <= bus3.op_out;
        d2_r <= d1_r;
    end
    assign bus3.res_in = d2_r;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] golden_sig(input logic [7:0] seed);
        logic [7:0] s;
        s = seed;
        for (int v = 0; v < 256; v++) begin
            s = {s[6:0], s[7]} ^ 8'(v);
        end
        return s;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.load_valid = 1'b0; bus.load_sel = 1'b0; bus.load_data = 4'h0;
        bus3.start = 1'b0; bus3.load_valid = 1'b0; bus3.load_sel = 1'b0; bus3.load_data = 4'h0;
    endtask

    // One manual load on dut, optionally poking start while it settles.
    task automatic do_load(input logic sel, input logic [3:0] data, input logic poke_start);
        int lat;
        bus.load_valid = 1'b1; bus.load_sel = sel; bus.load_data = data;
        tick();
        bus.load_valid = 1'b0;
        bus.load_data  = 4'($urandom);
        check_eq("man_busy", 32'(bus.busy), 32'd1);
        if (sel) b_m = data;
        else     a_m = data;
        bus.start = poke_start;
        lat = 0;
        do begin
            tick();
            bus.start = 1'b0;
            lat++;
        end while (lat < 20 && bus.res_valid !== 1'b1);
        check_eq("man_latency", 32'(lat), 32'(S2 + 1));
        check_eq("man_op", 32'(bus.op_out), 32'({b_m, a_m}));
        check_eq("man_res", 32'(bus.res_q), 32'({4'h0, a_m} + {4'h0, b_m}));
        check_eq("man_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int w, busy_n, rv_n, seq_err, hi_err;

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) tick();
        check_eq("por_op", 32'(bus.op_out), 32'h0);
        check_eq("por_sig3", 32'(bus3.sig_q), 32'(SEED3));
        rst_n = 1'b1;
        tick();

        // ---- Asynchronous reset in the middle of a sweep ----
        add_mode  = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        w = 0;
        while (bus.op_out !== 8'h37 && w < 400) begin
            tick();
            w++;
        end
        check_eq("reach_37", 32'(bus.op_out), 32'h37);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_op", 32'(bus.op_out), 32'h0);
        check_eq("rst_res_q", 32'(bus.res_q), 32'h0);
        check_eq("rst_sig", 32'(bus.sig_q), 32'(SEED2));
        check_eq("rst_busy", 32'(bus.busy), 32'h0);
        check_eq("rst_res_valid", 32'(bus.res_valid), 32'h0);
        check_eq("rst_sig3", 32'(bus3.sig_q), 32'(SEED3));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_busy", 32'(bus.busy), 32'h0);

        // ---- Manual loads with the A+B adder model ----
        add_mode = 1'b1;
        a_m = 4'h0;
        b_m = 4'h0;
        do_load(1'b0, 4'h3, 1'b0);
        do_load(1'b1, 4'h5, 1'b0);
        check_eq("load_53_op", 32'(bus.op_out), 32'h53);
        check_eq("load_53_res", 32'(bus.res_q), 32'h08);
        tick();
        check_eq("res_valid_width", 32'(bus.res_valid), 32'h0);

        for (int i = 0; i < 10; i++) begin
            do_load(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'(i % 2));
        end

        // ---- Full sweep, pass-through adder, random load/start pokes ----
        add_mode  = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        busy_n  = 0;
        rv_n    = 0;
        seq_err = 0;
        for (int k = 1; k <= 600; k++) begin
            if (bus.busy === 1'b1) begin
                busy_n++;
                if (bus.op_out !== 8'((k - 1) / S2)) seq_err++;
            end
            if (bus.res_valid === 1'b1) rv_n++;
            if (k < 480 && $urandom_range(0, 5) == 0) begin
                bus.load_valid = 1'b1;
                bus.load_sel   = 1'($urandom_range(0, 1));
                bus.load_data  = 4'($urandom_range(0, 15));
            end else begin
                bus.load_valid = 1'b0;
            end
            bus.start = (k < 480) && ($urandom_range(0, 9) == 0);
            tick();
        end
        idle_inputs();
        check_eq("sweep_busy_cycles", 32'(busy_n), 32'(256 * S2));
        check_eq("sweep_res_valid_count", 32'(rv_n), 32'd256);
        check_eq("sweep_op_sequence_errs", 32'(seq_err), 32'd0);
        check_eq("sweep_res_q", 32'(bus.res_q), 32'hFF);
        check_eq("sweep_op_final", 32'(bus.op_out), 32'hFF);
        check_eq("sweep_sig", 32'(bus.sig_q), 32'(golden_sig(SEED2)));

        // ---- start and load_valid together: start wins ----
        bus.start = 1'b1; bus.load_valid = 1'b1; bus.load_sel = 1'b1; bus.load_data = 4'hA;
        tick();
        idle_inputs();
        check_eq("prio_first_op", 32'(bus.op_out), 32'h00);
        hi_err = 0;
        for (int k = 1; k <= 4 * S2; k++) begin
            if (bus.op_out[7:4] !== 4'h0) hi_err++;
            tick();
        end
        check_eq("prio_b_nibble_errs", 32'(hi_err), 32'd0);
        w = 0;
        while (bus.busy === 1'b1 && w < 700) begin
            tick();
            w++;
        end
        check_eq("prio_sweep_done", 32'(bus.busy), 32'd0);
        check_eq("prio_sig", 32'(bus.sig_q), 32'(golden_sig(SEED2)));

        // ---- SETTLE_CYC=3 sweep with a 2-cycle-late adder ----
        bus3.start = 1'b1;
        tick();
        bus3.start = 1'b0;
        busy_n  = 0;
        rv_n    = 0;
        seq_err = 0;
        for (int k = 1; k <= 800; k++) begin
            if (bus3.busy === 1'b1) begin
                busy_n++;
                if (bus3.op_out !== 8'((k - 1) / S3)) seq_err++;
            end
            if (bus3.res_valid === 1'b1) rv_n++;
            tick();
        end
        check_eq("s3_busy_cycles", 32'(busy_n), 32'(256 * S3));
        check_eq("s3_res_valid_count", 32'(rv_n), 32'd256);
        check_eq("s3_window_stability_errs", 32'(seq_err), 32'd0);
        check_eq("s3_res_q", 32'(bus3.res_q), 32'hFF);
        check_eq("s3_sig", 32'(bus3.sig_q), 32'(golden_sig(SEED3)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
